led7_ring_seq: RTL
==================

Name: led7_ring_seq

Overview:
Sequencer that generates the 4-bit position index for the two-digit 7-segment "running segment" animation, the producer side of the idx bus. It walks idx through positions 0..11 at a programmable rate, forward or backward. It also supports single-stepping through a req/ack handshake. It sits between the board switches/buttons and the idx-to-segment decoder, and drives that decoder's idx input directly.

Parameters:
CLK_DIV, 25000000, clk cycles per step at speed 0; must be >= 8.
IDX_LAST, 11, highest valid position; idx wraps between IDX_LAST and 0.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  level; 1 = free-run animation, 0 = stopped/manual
dir  input  1  0 = forward (idx increments), 1 = reverse (idx decrements)
speed  input  2  rate select; step period = CLK_DIV >> speed cycles
step_req  input  1  manual-step request, level, honoured only when stopped
step_ack  output  1  one-cycle pulse: manual step performed
idx  output  4  current position, always 0..IDX_LAST
tick  output  1  one-cycle pulse on each automatic advance
lap  output  1  one-cycle pulse when idx wraps (IDX_LAST->0 forward, 0->IDX_LAST reverse)
running  output  1  1 while in RUN state

Behaviour:
- Reset (async, rst=1): state=STOP, idx=0, prescaler count=0. tick, lap, step_ack and running are all 0. Release is synchronous to clk.
- Prescaler limit L = CLK_DIV >> speed.
  - In RUN, the count increments every cycle.
  - When count >= L-1, the count returns to 0 and tick=1 for that cycle.
  - A speed change mid-count takes effect immediately. If count already >= new L-1, the tick fires on the next cycle.
  - Outside RUN, the count is held at 0.
- Advance rule, applied on tick and on manual step; idx updates on the same edge that registers tick/step_ack:
  - dir=0: idx = (idx==IDX_LAST) ? 0 : idx+1.
  - dir=1: idx = (idx==0) ? IDX_LAST : idx-1.
  - lap=1 in the same cycle as tick/step_ack whenever a wrap occurs.
- dir is sampled at each advance. A change between advances affects only the next advance.
- FSM states: STOP, RUN, STEP_HOLD.
  - STOP: en=1 -> RUN (count starts at 0; first tick exactly L cycles after the cycle en is sampled). Else step_req=1 -> advance once, step_ack=1, -> STEP_HOLD. en has priority over step_req when both are high.
  - RUN: running=1. en=0 -> STOP next edge; idx holds, count clears, and no tick is issued on that edge. step_req is ignored.
  - STEP_HOLD: waits for step_req=0, so a held button gives exactly one step. Then goes to RUN if en=1, else STOP. en is ignored while step_req stays high. No further advances occur in this state.
- Outputs are registered. tick, step_ack and lap are never high for more than one consecutive cycle per event.
- idx never leaves 0..IDX_LAST, including across speed/dir changes and reset.
- Reset asserted mid-RUN or mid-STEP_HOLD: immediate return to the reset values; no pulse is emitted.

Decomposition:
- Shared package/include led7_pkg: FSM state encodings (ST_STOP, ST_RUN, ST_STEP_HOLD), IDX_LAST default 11, IDX_W=4.
- Sub-module led7_prescaler: inputs clk, rst, run, limit; output tick. It holds the counter and the >= compare.
- Top module: FSM, the idx up/down wrap logic and the lap/step_ack pulse generation.

Test Plan:
- Reset then idle: rst pulse, en=0, step_req=0 for 100 cycles -> idx=0; tick, lap, step_ack and running stay 0.
- Forward run: CLK_DIV=8, speed=0, dir=0, en=1 -> tick every 8 cycles; idx 0,1,...,11,0; lap pulses exactly on the 11->0 advance (12th tick).
- Reverse and speed change: from idx=0 set dir=1, speed=2 (L=2) -> first tick gives idx=11 with lap=1; ticks then every 2 cycles: 10, 9, ...
- Manual step handshake: en=0, hold step_req high 20 cycles -> exactly one step_ack, idx 0->1. Release, reassert -> idx=2, second step_ack.
- Simultaneous/stop: in STOP raise en and step_req together -> RUN, no step_ack. Drop en mid-count -> idx frozen, tick=0, running=0 next cycle.
- Async reset mid-run: assert rst between clk edges while idx=7 -> idx=0 and running=0 before the next edge; no lap or tick is emitted.

Source files
------------

// File: rtl/led7_pkg.sv
// Shared constants and the position-advance rule for the running-segment sequencer.
package led7_pkg;

   localparam int IDX_W        = 4;
   localparam int IDX_LAST_DEF = 11;

   localparam logic [1:0] ST_STOP      = 2'd0;
   localparam logic [1:0] ST_RUN       = 2'd1;
   localparam logic [1:0] ST_STEP_HOLD = 2'd2;

   // One step around the ring, wrapping between last and 0 in either direction.
   function automatic logic [IDX_W-1:0] idx_advance(input logic [IDX_W-1:0] cur,
                                                    input logic             rev,
                                                    input logic [IDX_W-1:0] last);
      if (rev)
         return (cur == '0) ? last : cur - IDX_W'(1);
      else
         return (cur == last) ? '0 : cur + IDX_W'(1);
   endfunction

endpackage

// File: rtl/led7_prescaler.sv
// Step-rate prescaler: counts while run is high and flags the cycle the limit is reached.
module led7_prescaler #(
   parameter int CNT_W = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [CNT_W-1:0] limit,
   output logic             tick
);

   logic [CNT_W-1:0] count;

   // A >= compare lets a speed increase that overshoots the new limit fire on the very next cycle.
   assign tick = run && (count >= limit - CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (!run || tick)
         count <= '0;
      else
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/led7_ring_seq.sv
// Position sequencer for the two-digit running-segment animation: free-run or
// single-step through positions 0..IDX_LAST, forward or reverse.
module led7_ring_seq
   import led7_pkg::*;
#(
   parameter int CLK_DIV  = 25000000,
   parameter int IDX_LAST = IDX_LAST_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       speed,
   input  logic             step_req,
   output logic             step_ack,
   output logic [IDX_W-1:0] idx,
   output logic             tick,
   output logic             lap,
   output logic             running
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(IDX_LAST);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             do_step;
   logic             pre_tick;
   logic             adv;
   logic             wrap;
   logic [CNT_W-1:0] limit;

   assign limit = CNT_W'(CLK_DIV) >> speed;

   // Dropping en in RUN stops the prescaler on that same edge, so no late tick slips out.
   led7_prescaler #(.CNT_W(CNT_W)) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .run   ((state == ST_RUN) && en),
      .limit (limit),
      .tick  (pre_tick)
   );

   always_comb begin
      state_nxt = state;
      do_step   = 1'b0;
      case (state)
         ST_STOP: begin
            if (en)
               state_nxt = ST_RUN;
            else if (step_req) begin
               state_nxt = ST_STEP_HOLD;
               do_step   = 1'b1;
            end
         end
         ST_RUN: begin
            if (!en)
               state_nxt = ST_STOP;
         end
         ST_STEP_HOLD: begin
            if (!step_req)
               state_nxt = en ? ST_RUN : ST_STOP;
         end
         default: state_nxt = ST_STOP;
      endcase
   end

   assign adv  = pre_tick || do_step;
   assign wrap = dir ? (idx == '0) : (idx == LAST);

   // idx and the event pulses share one edge so lap always lines up with tick/step_ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_STOP;
         idx      <= '0;
         tick     <= 1'b0;
         step_ack <= 1'b0;
         lap      <= 1'b0;
      end else begin
         state    <= state_nxt;
         tick     <= pre_tick;
         step_ack <= do_step;
         lap      <= adv && wrap;
         if (adv)
            idx <= idx_advance(idx, dir, LAST);
      end
   end

   assign running = (state == ST_RUN);

endmodule
